ooo_read_responder: RTL and testbench
=====================================

OOO_READ_RESPONDER -- requirements
Module: ooo_read_responder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, R data width; ADDR_WIDTH, default 4, address width (memory depth 2**ADDR_WIDTH); SLOTS, default 4, number of outstanding reads; LAT_BASE, default 2, base latency; LAT_STEP, default 2, latency added per ID step.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low; ports are listed below.
REQ-003 clk  in  1  clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 s_arid_i  in  4  AR ID.
REQ-006 s_araddr_i  in  ADDR_WIDTH  AR address.
REQ-007 s_arvalid_i / s_arready_o  in / out  1  AR handshake.
REQ-008 s_rdata_o  out  DATA_WIDTH  R data.
REQ-009 s_rid_o  out  4  R ID.
REQ-010 s_rvalid_o / s_rready_i  out / in  1  R handshake.
REQ-011 cfg_we_i, cfg_addr_i[ADDR_WIDTH], cfg_data_i[DATA_WIDTH]  in  memory preload write port.

Function
REQ-012 Internal memory SHALL hold 2**ADDR_WIDTH words. A write with cfg_we_i=1 SHALL update mem[cfg_addr_i] at the clock edge.
REQ-013 Each slot SHALL be in exactly one of FREE, WAIT or READY.
REQ-014 s_arready_o SHALL be 1 iff at least one slot is FREE; it SHALL be independent of s_arvalid_i.
REQ-015 Accept (s_arvalid_i & s_arready_o) SHALL load the lowest-index FREE slot with: ID, data mem[s_araddr_i] (pre-edge value), and count L = LAT_BASE + LAT_STEP*s_arid_i[1:0]. The slot SHALL enter WAIT.
REQ-016 At most one AR SHALL be accepted per cycle.
REQ-017 A cfg write and an accept to the same address in the same cycle SHALL capture the old data.
REQ-018 WAIT: the count SHALL decrement every cycle. When the count is 1 the slot SHALL move to READY at that edge. A slot SHALL therefore be READY exactly L cycles after its accept edge.
REQ-019 An age matrix SHALL record relative accept order of occupied slots.
REQ-020 The arbiter SHALL grant the oldest READY slot. Consequences: same-ID responses return in accept order; different IDs may return out of order.
REQ-021 R output SHALL be a single register stage. It SHALL load the granted slot's ID and data when s_rvalid_o=0 or (s_rvalid_o & s_rready_i). The granted slot SHALL return to FREE at that same edge.
REQ-022 With no contention, s_rvalid_o SHALL rise L+1 cycles after the accept edge.
REQ-023 While s_rvalid_o=1 and s_rready_i=0, s_rdata_o and s_rid_o SHALL hold stable.
REQ-024 If a handshake completes and no slot is READY, s_rvalid_o SHALL fall at the next edge.
REQ-025 A slot freed at edge N SHALL be visible in s_arready_o after edge N. A freed slot and a new accept into that slot at the same edge SHALL NOT occur.
REQ-026 L SHALL be at least 1; LAT_BASE=0 with ID[1:0]=0 SHALL be treated as L=1.

Reset
REQ-027 While rst_n=0: all slots FREE, age matrix cleared, s_rvalid_o=0, s_rdata_o=0, s_rid_o=0; s_arready_o=1.
REQ-028 Memory SHALL reset to mem[a]=a, truncated or zero-extended to DATA_WIDTH.
REQ-029 Reset asserted mid-operation SHALL discard all outstanding reads with no R beat issued afterwards.

Verification (defaults; s_rready_i=1 unless stated)
REQ-030 Out-of-order return: accept id=3 addr=5 at edge 0 and id=0 addr=9 at edge 1. Required: R {id0, data 9} valid after edge 4, then R {id3, data 5} valid after edge 9.
REQ-031 Full: accept 4 ARs, all id=3, back to back. Required: s_arready_o=0 after the fourth accept; a fifth pending AR is accepted only after the first R handshake frees a slot.
REQ-032 Same-ID ordering under backpressure: accept id=1 addr=2, then id=1 addr=3, with s_rready_i=0 for 10 cycles. Required: data 2 is held stable first, then data 3 is delivered; never the reverse.
REQ-033 Preload: cfg write addr=7 data=0xA5, then AR id=0 addr=7. Required: R data 0xA5.
REQ-034 Same-cycle cfg write (addr=4, data=0x11) with AR to addr=4. Required: R data 0x04.
REQ-035 Reset mid-flight: 3 outstanding reads, pulse rst_n low for 1 cycle. Required: no R beat afterwards, s_arready_o=1, and s_rdata_o=0 immediately on assertion.

Source files
------------

// File: rtl/ooo_read_responder.sv
// rtl/ooo_read_responder.sv - out-of-order read responder with per-ID latency, age-ordered R arbitration
module ooo_read_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int SLOTS      = 4,
    parameter int LAT_BASE   = 2,
    parameter int LAT_STEP   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            s_arid_i,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [3:0]            s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    input  logic                  cfg_we_i,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0] cfg_data_i
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = 16;
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {FREE, WAIT, READY} slot_state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    slot_state_e           st_q   [SLOTS];
    slot_state_e           st_d   [SLOTS];
    logic [3:0]            id_q   [SLOTS];
    logic [3:0]            id_d   [SLOTS];
    logic [DATA_WIDTH-1:0] data_q [SLOTS];
    logic [DATA_WIDTH-1:0] data_d [SLOTS];
    logic [CNT_W-1:0]      cnt_q  [SLOTS];
    logic [CNT_W-1:0]      cnt_d  [SLOTS];
    // age_q[i][j] = 1 means slot i was accepted before slot j
    logic [SLOTS-1:0]      age_q  [SLOTS];
    logic [SLOTS-1:0]      age_d  [SLOTS];

    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            rid_q, rid_d;

    logic             acc_found, accept;
    logic [IDX_W-1:0] acc_idx;
    logic             gnt_found, older, r_load, take;
    logic [IDX_W-1:0] gnt_idx;
    logic [31:0]      lat_raw;
    logic [CNT_W-1:0] lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) mem_q[a] <= DATA_WIDTH'(a);
        end else if (cfg_we_i) begin
            mem_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    always_comb begin
        acc_found = 1'b0;
        acc_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (st_q[i] == FREE) begin
                acc_found = 1'b1;
                acc_idx   = IDX_W'(i);
            end
        end
    end

    assign s_arready_o = acc_found;
    assign accept      = s_arvalid_i & acc_found;

    // A zero computed latency would never leave WAIT, so it is clamped to one cycle
    always_comb begin
        lat_raw = 32'(LAT_BASE) + 32'(LAT_STEP) * {30'd0, s_arid_i[1:0]};
        lat     = (lat_raw == 32'd0) ? CNT_W'(1) : CNT_W'(lat_raw);
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        older     = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (st_q[i] == READY) begin
                older = 1'b1;
                for (int j = 0; j < SLOTS; j++) begin
                    if (j != i && st_q[j] == READY && !age_q[i][j]) older = 1'b0;
                end
                if (older) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign r_load = !rvalid_q || s_rready_i;
    assign take   = r_load && gnt_found;

    always_comb begin
        st_d   = st_q;
        id_d   = id_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        age_d  = age_q;
        for (int i = 0; i < SLOTS; i++) begin
            if (st_q[i] == WAIT) begin
                if (cnt_q[i] == CNT_W'(1)) st_d[i] = READY;
                else                       cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        if (take) begin
            st_d[gnt_idx]  = FREE;
            age_d[gnt_idx] = '0;
            for (int j = 0; j < SLOTS; j++) age_d[j][gnt_idx] = 1'b0;
        end
        // The accepted slot was FREE this cycle, so it can never be the granted one
        if (accept) begin
            st_d[acc_idx]   = WAIT;
            id_d[acc_idx]   = s_arid_i;
            data_d[acc_idx] = mem_q[s_araddr_i];
            cnt_d[acc_idx]  = lat;
            age_d[acc_idx]  = '0;
            for (int j = 0; j < SLOTS; j++) begin
                age_d[j][acc_idx] = (st_q[j] != FREE) && !(take && gnt_idx == IDX_W'(j));
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        if (r_load) begin
            rvalid_d = gnt_found;
            if (gnt_found) begin
                rdata_d = data_q[gnt_idx];
                rid_d   = id_q[gnt_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                st_q[i]   <= FREE;
                id_q[i]   <= '0;
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
                age_q[i]  <= '0;
            end
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            st_q     <= st_d;
            id_q     <= id_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            age_q    <= age_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
        end
    end

    assign s_rvalid_o = rvalid_q;
    assign s_rdata_o  = rdata_q;
    assign s_rid_o    = rid_q;
endmodule

// File: tb/tb_ooo_read_responder.sv
// tb/tb_ooo_read_responder.sv - vector table plus ID-matched scoreboard for ooo_read_responder
module tb_ooo_read_responder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] s_arid_i;
    logic [3:0] s_araddr_i;
    logic       s_arvalid_i;
    logic       s_arready_o;
    logic [7:0] s_rdata_o;
    logic [3:0] s_rid_o;
    logic       s_rvalid_o;
    logic       s_rready_i;
    logic       cfg_we_i;
    logic [3:0] cfg_addr_i;
    logic [7:0] cfg_data_i;

    ooo_read_responder dut (
        .clk(clk), .rst_n(rst_n),
        .s_arid_i(s_arid_i), .s_araddr_i(s_araddr_i),
        .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int n_hs  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [16];

    // Same-ID beats must come back in accept order, so match the oldest entry with that ID
    always @(negedge clk) begin : mon
        int found;
        if (!rst_n) begin
            sb.delete();
            for (int a = 0; a < 16; a++) model[a] = 8'(a);
        end else begin
            if (s_rvalid_o && s_rready_i) begin
                n_hs++;
                found = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (found < 0 && sb[k].id == s_rid_o) found = k;
                end
                if (found < 0) begin
                    chk("sb_unexpected_rid", {28'd0, s_rid_o}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_rdata", {24'd0, s_rdata_o}, {24'd0, sb[found].data});
                    sb.delete(found);
                end
            end
            if (s_arvalid_i && s_arready_o) sb.push_back('{s_arid_i, model[s_araddr_i]});
            if (cfg_we_i) model[cfg_addr_i] = cfg_data_i;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ar(input logic [3:0] id, input logic [3:0] addr);
        int n;
        s_arvalid_i = 1'b1;
        s_arid_i    = id;
        s_araddr_i  = addr;
        n = 0;
        @(negedge clk);
        while (!s_arready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!s_arready_o) chk("ar_timeout", 0, 1);
        step();
        s_arvalid_i = 1'b0;
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!s_rvalid_o && n < 60);
        if (!s_rvalid_o) chk("rvalid_timeout", 0, 1);
    endtask

    typedef struct {
        logic [3:0] id;
        logic [3:0] addr;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n, e0, seen, k;
        vecs[0] = '{4'h0, 4'h3, 8'h03, 3};
        vecs[1] = '{4'h1, 4'h5, 8'h05, 5};
        vecs[2] = '{4'h2, 4'hF, 8'h0F, 7};
        vecs[3] = '{4'h3, 4'h0, 8'h00, 9};
        vecs[4] = '{4'hC, 4'hA, 8'h0A, 3};
        vecs[5] = '{4'h6, 4'h1, 8'h01, 7};

        rst_n = 1'b0; s_arid_i = '0; s_araddr_i = '0; s_arvalid_i = 1'b0;
        s_rready_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
        repeat (2) step();
        chk("rst_arready", s_arready_o, 1);
        chk("rst_rvalid", s_rvalid_o, 0);
        chk("rst_rdata", s_rdata_o, 0);
        chk("rst_rid", s_rid_o, 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            ar(vecs[v].id, vecs[v].addr);
            wait_rvalid(n);
            chk("vec_latency", n, vecs[v].lat);
            chk("vec_rid", s_rid_o, vecs[v].id);
            chk("vec_rdata", s_rdata_o, vecs[v].data);
            step();
            chk("vec_rvalid_drop", s_rvalid_o, 0);
        end

        // out-of-order return across IDs
        e0 = cyc + 1;
        s_arvalid_i = 1'b1; s_arid_i = 4'd3; s_araddr_i = 4'd5;
        step();
        s_arid_i = 4'd0; s_araddr_i = 4'd9;
        step();
        s_arvalid_i = 1'b0;
        wait_rvalid(n);
        chk("ooo_first_cycle", cyc, e0 + 4);
        chk("ooo_first_rid", s_rid_o, 0);
        chk("ooo_first_rdata", s_rdata_o, 8'h09);
        step();
        wait_rvalid(n);
        chk("ooo_second_cycle", cyc, e0 + 9);
        chk("ooo_second_rid", s_rid_o, 3);
        chk("ooo_second_rdata", s_rdata_o, 8'h05);
        step();

        // all slots full, fifth AR stalls until a slot is handed to R
        e0 = cyc + 1;
        s_arvalid_i = 1'b1; s_arid_i = 4'd3;
        for (int i = 0; i < 4; i++) begin
            s_araddr_i = 4'(i);
            step();
        end
        s_araddr_i = 4'd8;
        chk("full_arready_low", s_arready_o, 0);
        k = 0;
        @(negedge clk);
        while (!s_arready_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("full_accept_edge", cyc + 1, e0 + 10);
        step();
        s_arvalid_i = 1'b0;
        k = 0;
        while ((sb.size() != 0 || s_rvalid_o) && k < 80) begin
            step();
            k++;
        end
        chk("full_drained", sb.size(), 0);

        // same-ID ordering under backpressure
        s_rready_i = 1'b0;
        s_arvalid_i = 1'b1; s_arid_i = 4'd1; s_araddr_i = 4'd2;
        step();
        s_araddr_i = 4'd3;
        step();
        s_arvalid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_rvalid_o) begin
                seen++;
                chk("bp_hold_rdata", s_rdata_o, 8'h02);
                chk("bp_hold_rid", s_rid_o, 1);
            end
        end
        chk("bp_seen_valid", seen > 0, 1);
        step();
        s_rready_i = 1'b1;
        @(negedge clk);
        chk("bp_first_rdata", s_rdata_o, 8'h02);
        @(negedge clk);
        chk("bp_second_valid", s_rvalid_o, 1);
        chk("bp_second_rdata", s_rdata_o, 8'h03);
        step();

        // preload then read
        cfg_we_i = 1'b1; cfg_addr_i = 4'd7; cfg_data_i = 8'hA5;
        step();
        cfg_we_i = 1'b0;
        ar(4'd0, 4'd7);
        wait_rvalid(n);
        chk("preload_rdata", s_rdata_o, 8'hA5);
        step();

        // same-cycle write and read see old data; the next read sees the new data
        cfg_we_i = 1'b1; cfg_addr_i = 4'd4; cfg_data_i = 8'h11;
        s_arvalid_i = 1'b1; s_arid_i = 4'd0; s_araddr_i = 4'd4;
        step();
        cfg_we_i = 1'b0; s_arvalid_i = 1'b0;
        wait_rvalid(n);
        chk("collide_old_rdata", s_rdata_o, 8'h04);
        step();
        ar(4'd0, 4'd4);
        wait_rvalid(n);
        chk("collide_new_rdata", s_rdata_o, 8'h11);
        step();

        // reset mid-flight discards everything
        s_arvalid_i = 1'b1; s_arid_i = 4'd3;
        for (int i = 1; i < 4; i++) begin
            s_araddr_i = 4'(i);
            step();
        end
        s_arvalid_i = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", s_rdata_o, 0);
        chk("midrst_rvalid", s_rvalid_o, 0);
        chk("midrst_arready", s_arready_o, 1);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_rvalid_o) seen++;
        end
        chk("midrst_no_beats", seen, 0);
        chk("midrst_arready_after", s_arready_o, 1);
        step();
        ar(4'd0, 4'd7);
        wait_rvalid(n);
        chk("midrst_mem_restored", s_rdata_o, 8'h07);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
